fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined successor of the single-cycle MIPS32 core.
- Owns the fetch PC and drives the combinational instruction ROM.
- Buffers fetched instructions, with their PC and PC+4, in a DEPTH-entry queue toward decode under a valid/ready handshake.
- Handles control-flow redirects (branch/jump/jr target, interrupt vector, exception vector) by flushing the queue and reloading the fetch PC.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_queue_if.sv | 11 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_queue.sv | 70 +++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect kinds, default fetch vectors and the queue entry layout.
package cpu_pkg;

  localparam logic [1:0] REDIR_TGT = 2'd0;
  localparam logic [1:0] REDIR_INT = 2'd1;
  localparam logic [1:0] REDIR_EXC = 2'd2;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VEC  = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } fetch_entry_t;

  // Kind 3 is reserved and behaves like an explicit target; targets are word aligned.
  function automatic logic [31:0] redir_target(input logic [1:0] kind,
                                               input logic [31:0] pc,
                                               input logic [31:0] int_vec,
                                               input logic [31:0] exc_vec);
    logic [31:0] tgt;
    case (kind)
      REDIR_INT: tgt = int_vec;
      REDIR_EXC: tgt = exc_vec;
      default:   tgt = {pc[31:2], 2'b00};
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake: head entry of the fetch queue under valid/ready.
interface fetch_queue_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;

  modport master (output out_valid, out_instr, out_pc, out_pcp4, input out_ready);
  modport slave  (input out_valid, out_instr, out_pc, out_pcp4, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Full-with-pop writes the slot being read; the old value is consumed before the edge.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, drives the ROM and queues fetches toward decode.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] INT_VEC  = DEF_INT_VEC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redir_valid,
  input  logic [1:0]             redir_kind,
  input  logic [31:0]            redir_pc,
  fetch_queue_if.master          dq,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]  fpc_reg, fpc_next;
  logic         push, pop, empty;
  fetch_entry_t wr_entry, head_entry;

  assign pop  = dq.out_valid & dq.out_ready;
  assign push = !redir_valid && ((q_count < FULL_COUNT) || pop);

  always_comb begin
    fpc_next = fpc_reg;
    if (redir_valid)
      fpc_next = redir_target(redir_kind, redir_pc, INT_VEC, EXC_VEC);
    else if (push)
      fpc_next = fpc_reg + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fpc_reg <= RESET_PC;
    else        fpc_reg <= fpc_next;
  end

  // The ROM never sees the kernel bit; the queued PC keeps it for decode.
  assign imem_addr = {1'b0, fpc_reg[30:0]};

  assign wr_entry.instr = imem_data;
  assign wr_entry.pc    = fpc_reg;
  assign wr_entry.pcp4  = fpc_reg + 32'd4;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redir_valid),
    .din   (wr_entry),
    .dout  (head_entry),
    .count (q_count),
    .empty (empty)
  );

  assign dq.out_valid = !empty;
  assign dq.out_instr = empty ? 32'd0 : head_entry.instr;
  assign dq.out_pc    = empty ? 32'd0 : head_entry.pc;
  assign dq.out_pcp4  = empty ? 32'd0 : head_entry.pcp4;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomised bench for fetch_queue with a scoreboard of expected queue entries.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam logic [31:0] ROM_KEY = 32'hC3A5_5A3C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc;
  logic [2:0]  q_count;

  fetch_queue_if dq();

  fetch_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_pc    (redir_pc),
    .dq          (dq),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;
  assign imem_data = imem_addr ^ ROM_KEY;

  int n_cmp = 0;
  int n_err = 0;
  fetch_entry_t sb[$];
  logic [31:0]  acc[$];
  logic [31:0]  m_fpc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return {1'b0, pc[30:0]} ^ ROM_KEY;
  endfunction

  // Compare DUT against the scoreboard, then advance the model for this cycle's inputs.
  task automatic step();
    fetch_entry_t e;
    logic pop_m;
    check("valid", 32'(dq.out_valid), 32'(sb.size() != 0));
    check("count", 32'(q_count), 32'(sb.size()));
    check("imem_addr", imem_addr, {1'b0, m_fpc[30:0]});
    if (sb.size() != 0) begin
      check("instr", dq.out_instr, sb[0].instr);
      check("pc", dq.out_pc, sb[0].pc);
      check("pcp4", dq.out_pcp4, sb[0].pcp4);
    end
    pop_m = (sb.size() != 0) && dq.out_ready;
    if (pop_m) acc.push_back(sb[0].pc);
    if (redir_valid) begin
      sb.delete();
      case (redir_kind)
        2'd1:    m_fpc = 32'h8000_0004;
        2'd2:    m_fpc = 32'h8000_0008;
        default: m_fpc = redir_pc & 32'hFFFF_FFFC;
      endcase
    end else if (sb.size() < 4 || pop_m) begin
      if (pop_m) void'(sb.pop_front());
      e.instr = rom(m_fpc);
      e.pc    = m_fpc;
      e.pcp4  = m_fpc + 32'd4;
      sb.push_back(e);
      m_fpc = m_fpc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(dq.out_valid), 32'd0);
    check("rst_count", 32'(q_count), 32'd0);
    sb.delete();
    acc.delete();
    m_fpc = 32'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [31:0] pc);
    redir_valid = 1'b1;
    redir_kind  = kind;
    redir_pc    = pc;
    step();
    redir_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    redir_valid = 1'b0;
    redir_kind = 2'd0;
    redir_pc = 32'h0;
    dq.out_ready = 1'b1;
    m_fpc = 32'h0;
    #1;
    check("rst_valid", 32'(dq.out_valid), 32'd0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_pc", dq.out_pc, 32'd0);
    check("rst_pcp4", dq.out_pcp4, 32'd0);
    check("rst_instr", dq.out_instr, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Streaming with decode always ready
    step();
    check("t1_first_valid", 32'(dq.out_valid), 32'd1);
    check("t1_first_pc", dq.out_pc, 32'h0);
    repeat (4) step();
    check("t1_pops", 32'(acc.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc.size(); i++) check("t1_seq", acc[i], 32'(i * 4));

    // Backpressure fills the queue, then drains in order
    do_reset();
    dq.out_ready = 1'b0;
    repeat (10) step();
    check("t2_full_count", 32'(q_count), 32'd4);
    check("t2_hold_addr", imem_addr, 32'h10);
    dq.out_ready = 1'b1;
    repeat (6) step();
    check("t2_pops", 32'(acc.size()), 32'd6);
    for (int i = 0; i < 5 && i < acc.size(); i++) check("t2_seq", acc[i], 32'(i * 4));

    // Explicit target redirect flushes a partially filled queue
    do_reset();
    dq.out_ready = 1'b0;
    repeat (3) step();
    check("t3_pre_count", 32'(q_count), 32'd3);
    redirect(2'd0, 32'h0000_0043);
    check("t3_count", 32'(q_count), 32'd0);
    check("t3_valid", 32'(dq.out_valid), 32'd0);
    check("t3_addr", imem_addr, 32'h40);
    step();
    check("t3_pc", dq.out_pc, 32'h40);
    check("t3_instr", dq.out_instr, 32'h40 ^ ROM_KEY);

    // Interrupt and exception vectors, with decode ready during the redirect
    dq.out_ready = 1'b1;
    redirect(2'd1, 32'h1234_5678);
    check("t4_int_addr", imem_addr, 32'h0000_0004);
    step();
    check("t4_int_pc", dq.out_pc, 32'h8000_0004);
    check("t4_int_pcp4", dq.out_pcp4, 32'h8000_0008);
    redirect(2'd2, 32'h0);
    step();
    check("t4_exc_pc", dq.out_pc, 32'h8000_0008);

    // Back-to-back redirects: the last one wins; reserved kind acts as a target
    redirect(2'd1, 32'h0);
    redirect(2'd3, 32'h0000_0301);
    step();
    check("t4_b2b_pc", dq.out_pc, 32'h300);

    // Wrap at the top of the address space
    redirect(2'd0, 32'hFFFF_FFFC);
    check("t5_addr", imem_addr, 32'h7FFF_FFFC);
    step();
    check("t5_pc", dq.out_pc, 32'hFFFF_FFFC);
    check("t5_pcp4", dq.out_pcp4, 32'h0);
    step();
    check("t5_wrap_pc", dq.out_pc, 32'h0);

    // Random ready and redirect traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      dq.out_ready = ($urandom_range(0, 3) != 0);
      redir_valid  = ($urandom_range(0, 15) == 0);
      redir_kind   = 2'($urandom_range(0, 3));
      redir_pc     = $urandom;
      step();
    end
    redir_valid = 1'b0;

    // Asynchronous reset between clock edges with a full queue
    dq.out_ready = 1'b0;
    repeat (6) step();
    check("t6_full", 32'(q_count), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(dq.out_valid), 32'd0);
    check("t6_count", 32'(q_count), 32'd0);
    check("t6_pc_zero", dq.out_pc, 32'd0);
    sb.delete();
    acc.delete();
    m_fpc = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    dq.out_ready = 1'b1;
    step();
    check("t6_first_pc", dq.out_pc, 32'h0);
    check("t6_first_valid", 32'(dq.out_valid), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
